reg_port_ctrl: RTL and testbench
================================

REG_PORT_CTRL -- requirements
Module: reg_port_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of storage registers driven by the controller.
REQ-002 SHALL have parameter REG_W, default 16, data width per register.
REQ-003 SHALL have ports: clk  input  1  sole clock, rising edge; rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req_valid  input  1  read request; req_ready  output  1  request accepted when both high; src1_id, src2_id  input  4  register ids.
REQ-005 SHALL have ports: resp_valid  output  1  read data valid; resp_ready  input  1  consumer accepts; rd_data1, rd_data2  output  REG_W  read results.
REQ-006 SHALL have ports: wr_en  input  1  write strobe; wr_id  input  4  target id; wr_data  input  REG_W  write value.
REQ-007 SHALL have storage-side ports: write_reg  output  NUM_REGS  one-hot write wordline; d  output  REG_W  write data; rden1, rden2  output  NUM_REGS  one-hot read wordlines; bitline1, bitline2  inout  REG_W  shared read bitlines.

Function
REQ-008 SHALL never drive bitline1/bitline2 (always high-Z from this block); values are only sampled.
REQ-009 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-010 IDLE: req_ready=1; on req_valid&&req_ready, latch src1_id/src2_id, go to ACCESS.
REQ-011 ACCESS (exactly 1 cycle): req_ready=0; rden1=onehot(src1_id), rden2=onehot(src2_id); sample bitlines into rd_data1/rd_data2 at cycle end; go to RESP.
REQ-012 RESP: resp_valid=1, rd_data stable until resp_valid&&resp_ready, then IDLE; req_ready=0 in RESP.
REQ-013 Read latency: accept at edge N, resp_valid high in cycle N+2; max throughput one read per 3 cycles.
REQ-014 Id 0 SHALL read as 0: no rden bit asserted for that port, rd_data forced to 0.
REQ-015 Writes are independent of FSM state: write_reg=onehot(wr_id) and d=wr_data combinationally while wr_en=1 and wr_id!=0; storage commits at that edge.
REQ-016 wr_id=0 SHALL assert no write_reg bit (write discarded).
REQ-017 src1_id==src2_id SHALL assert the same rden bit on both ports; both outputs equal.
REQ-018 At most one bit of each of write_reg, rden1, rden2 SHALL be high in any cycle; all zero outside the cases above.

Reset
REQ-019 rst SHALL force state IDLE, resp_valid=0, rd_data1=rd_data2=0, latched ids=0 at the next edge.
REQ-020 While rst=1, write_reg, rden1, rden2 SHALL be 0 combinationally; req_ready=0.
REQ-021 rst during ACCESS or RESP SHALL abort the read; no response is produced.

Configuration
REQ-022 Macro REG_PORT_BYPASS_EN: when defined, in ACCESS, if wr_en=1, wr_id!=0 and wr_id equals a port's latched id, that port SHALL capture wr_data instead of its bitline.
REQ-023 Without REG_PORT_BYPASS_EN, ACCESS always captures bitlines (old value on same-cycle write hit).

Structure
REQ-024 Shared package regfile_pkg SHALL hold NUM_REGS, REG_W, REG_ID_W=4 and the FSM state encoding.
REQ-025 Sub-module reg_id_decoder (4-bit id + enable -> one-hot NUM_REGS, id 0 -> all zero) SHALL be instantiated three times.

Verification
REQ-026 Write R3=16'hA5A5, then read src1=3, src2=0 -> rd_data1=16'hA5A5, rd_data2=16'h0000 at N+2, rden2 never asserted.
REQ-027 Read src1=src2=7 after R7=16'h1234 -> rden1=rden2=16'h0080 in ACCESS, both outputs 16'h1234.
REQ-028 Write R5=16'hBEEF during ACCESS of read src1=5 (R5 previously 16'h0001) -> 16'hBEEF with REG_PORT_BYPASS_EN, 16'h0001 without.
REQ-029 Hold resp_ready=0 for 4 cycles in RESP -> resp_valid, rd_data stable, req_ready=0, new req_valid ignored.
REQ-030 Assert rst in ACCESS -> next cycle IDLE, resp_valid=0, rden1=rden2=0, no response emitted.
REQ-031 Write wr_id=0 with 16'hFFFF -> write_reg=0, subsequent read of id 0 returns 16'h0000.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-port controller slice.
//   NUM_REGS : default number of storage registers on the wordlines
//   REG_W    : default data width per register
//   REG_ID_W : width of a register id (id 0 is the hard-wired zero register)
//   state_e  : read-port FSM state encoding
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned REG_W    = 16;
  localparam int unsigned REG_ID_W = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

endpackage

// File: rtl/reg_id_decoder.sv
// ---------------------------------------------------------------------------
// reg_id_decoder
// Converts a register id into a one-hot wordline vector.
// Id 0 and ids beyond NUM_REGS-1 produce an all-zero vector, as does i_en=0.
// Ports:
//   i_en     : enable; when low the output is all zero
//   i_id     : register id (REG_ID_W bits)
//   o_onehot : one-hot wordline, NUM_REGS bits
// ---------------------------------------------------------------------------
module reg_id_decoder
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                i_en,
  input  logic [REG_ID_W-1:0] i_id,
  output logic [NUM_REGS-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    // Start at 1: register 0 is the constant-zero register and owns no wordline.
    for (int i = 1; i < int'(NUM_REGS); i++) begin
      if (i_en && (i_id == REG_ID_W'(i))) begin
        o_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_port_ctrl.sv
// ---------------------------------------------------------------------------
// reg_port_ctrl
// Two-read / one-write port controller for an external register array that
// exposes one-hot wordlines and shared read bitlines.
//
// Read path: IDLE accepts a request and latches both source ids, ACCESS
// asserts the read wordlines for exactly one cycle and samples the bitlines,
// RESP holds the result until the consumer takes it. Accept at edge N gives
// resp_valid in cycle N+2; at most one read every 3 cycles.
// Write path: independent of the FSM, write_reg/d are decoded combinationally
// from wr_en/wr_id/wr_data and the array commits on the clock edge.
// Id 0 reads as zero and discards writes.
//
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   req_valid/req_ready : read request handshake, src1_id/src2_id its ids
//   resp_valid/resp_ready, rd_data1/rd_data2 : read response handshake + data
//   wr_en, wr_id, wr_data : write request
//   write_reg, d        : one-hot write wordline and write data to the array
//   rden1, rden2        : one-hot read wordlines to the array
//   bitline1, bitline2  : shared read bitlines, sampled only, never driven
//
// Configuration macro:
//   REG_PORT_BYPASS_EN  : when defined, a write that hits a port's latched id
//                         during ACCESS is forwarded to that port instead of
//                         the (stale) bitline value.
// ---------------------------------------------------------------------------
module reg_port_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int unsigned REG_W    = regfile_pkg::REG_W
) (
  input  logic                clk,
  input  logic                rst,
  // Read request
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [REG_ID_W-1:0] src1_id,
  input  logic [REG_ID_W-1:0] src2_id,
  // Read response
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [REG_W-1:0]    rd_data1,
  output logic [REG_W-1:0]    rd_data2,
  // Write request
  input  logic                wr_en,
  input  logic [REG_ID_W-1:0] wr_id,
  input  logic [REG_W-1:0]    wr_data,
  // Storage side
  output logic [NUM_REGS-1:0] write_reg,
  output logic [REG_W-1:0]    d,
  output logic [NUM_REGS-1:0] rden1,
  output logic [NUM_REGS-1:0] rden2,
  inout  wire  [REG_W-1:0]    bitline1,
  inout  wire  [REG_W-1:0]    bitline2
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e              r_state;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [REG_ID_W-1:0] r_src1_id;
  logic [REG_ID_W-1:0] r_src2_id;
  logic [REG_W-1:0]    r_rd_data1;
  logic [REG_W-1:0]    r_rd_data2;

  // -------------------------------------------------------------------------
  // Wordline decode
  // -------------------------------------------------------------------------
  logic w_wr_dec_en;
  logic w_rd_dec_en;

  // Reset gates every wordline so a reset cycle can never disturb the array.
  assign w_wr_dec_en = wr_en && !rst;
  assign w_rd_dec_en = (r_state == StAccess) && !rst;

  reg_id_decoder #(
    .NUM_REGS (NUM_REGS)
  ) u_wr_dec (
    .i_en     (w_wr_dec_en),
    .i_id     (wr_id),
    .o_onehot (write_reg)
  );

  reg_id_decoder #(
    .NUM_REGS (NUM_REGS)
  ) u_rd1_dec (
    .i_en     (w_rd_dec_en),
    .i_id     (r_src1_id),
    .o_onehot (rden1)
  );

  reg_id_decoder #(
    .NUM_REGS (NUM_REGS)
  ) u_rd2_dec (
    .i_en     (w_rd_dec_en),
    .i_id     (r_src2_id),
    .o_onehot (rden2)
  );

  assign d = wr_data;

  // -------------------------------------------------------------------------
  // Capture value for each read port
  // -------------------------------------------------------------------------
  logic             w_src1_live;
  logic             w_src2_live;
  logic             w_hit1;
  logic             w_hit2;
  logic [REG_W-1:0] w_cap1;
  logic [REG_W-1:0] w_cap2;

  // A port only has a driven bitline when its id selects a real register;
  // otherwise the bitline floats and the port reads zero.
  assign w_src1_live = (r_src1_id != '0) && (32'(r_src1_id) < NUM_REGS);
  assign w_src2_live = (r_src2_id != '0) && (32'(r_src2_id) < NUM_REGS);

`ifdef REG_PORT_BYPASS_EN
  // The array commits the write at the same edge that samples the bitlines,
  // so the bitline still shows the old value; forward the new one instead.
  assign w_hit1 = wr_en && (wr_id != '0) && (wr_id == r_src1_id);
  assign w_hit2 = wr_en && (wr_id != '0) && (wr_id == r_src2_id);
`else
  assign w_hit1 = 1'b0;
  assign w_hit2 = 1'b0;
`endif

  always_comb begin
    w_cap1 = '0;
    w_cap2 = '0;
    if (w_src1_live) begin
      w_cap1 = w_hit1 ? wr_data : bitline1;
    end
    if (w_src2_live) begin
      w_cap2 = w_hit2 ? wr_data : bitline2;
    end
  end

  // -------------------------------------------------------------------------
  // Read FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_src1_id    <= '0;
      r_src2_id    <= '0;
      r_rd_data1   <= '0;
      r_rd_data2   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (req_valid && r_req_ready) begin
            r_src1_id   <= src1_id;
            r_src2_id   <= src2_id;
            r_req_ready <= 1'b0;
            r_state     <= StAccess;
          end
        end
        StAccess: begin
          r_rd_data1   <= w_cap1;
          r_rd_data2   <= w_cap2;
          r_resp_valid <= 1'b1;
          r_state      <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= StIdle;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= StIdle;
        end
      endcase
    end
  end

  // req_ready must drop in the very cycle rst is raised, not one edge later.
  assign req_ready  = r_req_ready && !rst;
  assign resp_valid = r_resp_valid;
  assign rd_data1   = r_rd_data1;
  assign rd_data2   = r_rd_data2;

endmodule

// File: tb/tb_reg_port_ctrl.sv
module tb_reg_port_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  src1_id;
  logic [3:0]  src2_id;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] rd_data1;
  logic [15:0] rd_data2;
  logic        wr_en;
  logic [3:0]  wr_id;
  logic [15:0] wr_data;
  logic [15:0] write_reg;
  logic [15:0] d;
  logic [15:0] rden1;
  logic [15:0] rden2;
  wire  [15:0] bitline1;
  wire  [15:0] bitline2;

  // Register array model: commits on write_reg, drives bitlines from rden.
  logic [15:0] mem [16];
  logic [15:0] bl1;
  logic [15:0] bl2;

  assign bitline1 = bl1;
  assign bitline2 = bl2;

  always_comb begin
    bl1 = '0;
    bl2 = '0;
    for (int i = 0; i < 16; i++) begin
      if (rden1[i]) bl1 = bl1 | mem[i];
      if (rden2[i]) bl2 = bl2 | mem[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (write_reg[i]) mem[i] <= d;
    end
  end

  reg_port_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .src1_id    (src1_id),
    .src2_id    (src2_id),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .rd_data1   (rd_data1),
    .rd_data2   (rd_data2),
    .wr_en      (wr_en),
    .wr_id      (wr_id),
    .wr_data    (wr_data),
    .write_reg  (write_reg),
    .d          (d),
    .rden1      (rden1),
    .rden2      (rden2),
    .bitline1   (bitline1),
    .bitline2   (bitline2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [15:0] data,
                          input logic [15:0] exp_wl, input string tag);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_id   = id;
    wr_data = data;
    #1;
    check({tag, "_write_reg"}, 32'(write_reg), 32'(exp_wl));
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  // One full read transaction; optionally writes during ACCESS.
  task automatic do_read(input logic [3:0] s1, input logic [3:0] s2,
                         input logic [15:0] e_rden1, input logic [15:0] e_rden2,
                         input logic [15:0] e_d1, input logic [15:0] e_d2,
                         input bit aw, input logic [3:0] aid, input logic [15:0] adata,
                         input string tag);
    @(negedge clk);
    check({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    src1_id   = s1;
    src2_id   = s2;
    @(negedge clk);  // ACCESS
    req_valid = 1'b0;
    src1_id   = 4'hF;
    src2_id   = 4'hF;
    if (aw) begin
      wr_en   = 1'b1;
      wr_id   = aid;
      wr_data = adata;
    end
    #1;
    check({tag, "_req_ready_access"}, 32'(req_ready), 32'd0);
    check({tag, "_rden1"}, 32'(rden1), 32'(e_rden1));
    check({tag, "_rden2"}, 32'(rden2), 32'(e_rden2));
    check({tag, "_resp_valid_access"}, 32'(resp_valid), 32'd0);
    @(negedge clk);  // RESP, cycle N+2
    wr_en = 1'b0;
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_rd_data1"}, 32'(rd_data1), 32'(e_d1));
    check({tag, "_rd_data2"}, 32'(rd_data2), 32'(e_d2));
    check({tag, "_rden_resp"}, 32'({rden1, rden2}), 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_resp_valid_done"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [15:0] exp_bypass;

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    src1_id    = '0;
    src2_id    = '0;
    wr_en      = 1'b1;  // must be masked while in reset
    wr_id      = 4'd3;
    wr_data    = 16'hDEAD;

    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_write_reg", 32'(write_reg), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rd_data", 32'({rd_data1, rd_data2}), 32'd0);
    wr_en = 1'b0;
    rst   = 1'b0;
    #1;
    check("rst_no_commit", 32'(mem[3]), 32'd0);

    // R3 = A5A5, read (3, 0)
    do_write(4'd3, 16'hA5A5, 16'h0008, "w3");
    do_read(4'd3, 4'd0, 16'h0008, 16'h0000, 16'hA5A5, 16'h0000, 1'b0, 4'd0, 16'h0, "rd3_0");

    // R7 = 1234, read (7, 7)
    do_write(4'd7, 16'h1234, 16'h0080, "w7");
    do_read(4'd7, 4'd7, 16'h0080, 16'h0080, 16'h1234, 16'h1234, 1'b0, 4'd0, 16'h0, "rd7_7");

    // Top register boundary
    do_write(4'd15, 16'hC3C3, 16'h8000, "w15");
    do_read(4'd15, 4'd3, 16'h8000, 16'h0008, 16'hC3C3, 16'hA5A5, 1'b0, 4'd0, 16'h0, "rd15_3");

    // Same-cycle write hit during ACCESS
    do_write(4'd5, 16'h0001, 16'h0020, "w5");
`ifdef REG_PORT_BYPASS_EN
    exp_bypass = 16'hBEEF;
`else
    exp_bypass = 16'h0001;
`endif
    do_read(4'd5, 4'd3, 16'h0020, 16'h0008, exp_bypass, 16'hA5A5, 1'b1, 4'd5, 16'hBEEF, "rd5_hit");
    do_read(4'd5, 4'd0, 16'h0020, 16'h0000, 16'hBEEF, 16'h0000, 1'b0, 4'd0, 16'h0, "rd5_after");

    // Write to id 0 is discarded; id 0 reads zero
    do_write(4'd0, 16'hFFFF, 16'h0000, "w0");
    do_read(4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4'd0, 16'h0, "rd0_0");

    // Back-pressure in RESP: hold resp_ready low for 4 cycles
    @(negedge clk);
    req_valid = 1'b1;
    src1_id   = 4'd7;
    src2_id   = 4'd3;
    @(negedge clk);
    src1_id = 4'd15;
    src2_id = 4'd15;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_rd_data", 32'({rd_data1, rd_data2}), 32'h1234A5A5);
      check("bp_rden", 32'({rden1, rden2}), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp_release", 32'(resp_valid), 32'd0);
    check("bp_idle_ready", 32'(req_ready), 32'd1);

    // Reset during ACCESS aborts the read
    @(negedge clk);
    req_valid = 1'b1;
    src1_id   = 4'd3;
    src2_id   = 4'd7;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("ab_rden1_pre", 32'(rden1), 32'h0008);
    rst = 1'b1;
    #1;
    check("ab_rden_rst", 32'({rden1, rden2}), 32'd0);
    check("ab_req_ready_rst", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ab_resp_valid", 32'(resp_valid), 32'd0);
    check("ab_rd_data", 32'({rd_data1, rd_data2}), 32'd0);
    check("ab_rden_idle", 32'({rden1, rden2}), 32'd0);
    check("ab_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("ab_no_resp", 32'(resp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
